// File: rtl/dmem_bus_ctrl.sv
//==============================================================================
// Module      : dmem_bus_ctrl
// Description : Data-memory access controller between the core datapath and a
//               variable-latency data RAM. Runs a req/ack bus cycle per
//               aligned load/store, stalls the core until completion, returns
//               load data and flags misaligned accesses and bus timeouts.
//               Optional feature macro: POSTED_WRITE_EN (1-entry posted
//               write buffer drained in the background by state WDRAIN).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignEr,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned    CW     = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  C_TMAX = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
`ifdef POSTED_WRITE_EN
    // The mem_* registers double as the write buffer; WDRAIN == buffer full.
    localparam logic [1:0] S_WDRAIN = 2'd3;
`endif

    logic [1:0]    state_q,     state_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [31:0]   mem_addr_q,  mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   rdata_q,     rdata_d;
    logic          misal_q,     misal_d;
    logic          buserr_q,    buserr_d;
    logic [CW-1:0] count_q,     count_d;

    logic w_acc;
    logic w_align;
    logic w_timeout;
    logic w_stall;

    assign w_acc     = MemRead | MemWrite;
    assign w_align   = (Addr[1:0] == 2'b00);
    assign w_timeout = (count_q == C_TMAX);

    // State and datapath registers; reset abandons any in-flight bus cycle.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            misal_q     <= 1'b0;
            buserr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            misal_q     <= misal_d;
            buserr_q    <= buserr_d;
            count_q     <= count_d;
        end
    end

    // Next-state logic: a bus cycle ends on ack or on the last timeout count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_acc && w_align) begin
`ifdef POSTED_WRITE_EN
                    state_d = MemWrite ? S_WDRAIN : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (mem_ack || w_timeout) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
`ifdef POSTED_WRITE_EN
            S_WDRAIN: begin
                if (mem_ack || w_timeout) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic: bus register updates, error pulses and Stall.
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        misal_d     = 1'b0;
        buserr_d    = 1'b0;
        count_d     = count_q;
        w_stall     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_acc && w_align) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWrite;
                    mem_addr_d  = {Addr[31:2], 2'b00};
                    mem_wdata_d = WriteData;
                    count_d     = '0;
`ifdef POSTED_WRITE_EN
                    // A posted store retires immediately.
                    w_stall     = ~MemWrite;
`else
                    w_stall     = 1'b1;
`endif
                end else if (w_acc) begin
                    misal_d = 1'b1;
                    rdata_d = 32'd0;
                end
            end
`ifdef POSTED_WRITE_EN
            S_REQ, S_WDRAIN: begin
`else
            S_REQ: begin
`endif
`ifdef POSTED_WRITE_EN
                // Any access waits for the drain to finish, then restarts from IDLE.
                w_stall = (state_q == S_WDRAIN) ? w_acc : (w_acc & w_align);
`else
                w_stall = w_acc & w_align;
`endif
                count_d = count_q + 1'b1;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) rdata_d = mem_rdata;
                end else if (w_timeout) begin
                    mem_req_d = 1'b0;
                    buserr_d  = 1'b1;
                    if (!mem_we_q) rdata_d = ERR_DATA;
                end
            end
            default: w_stall = 1'b0;
        endcase
    end

    // Stall is held low while reset is asserted so the core sees no freeze.
    assign Stall      = w_stall & reset;
    assign ReadData   = rdata_q;
    assign MisalignEr = misal_q;
    assign BusErr     = buserr_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
//==============================================================================
// Module      : tb_dmem_bus_ctrl
// Description : Self-checking bench for dmem_bus_ctrl: per-cycle vector table
//               plus hand-written timeout, reset and store sequences.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_bus_ctrl;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] Addr = '0, WriteData = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] ReadData, mem_addr, mem_wdata;
    logic        Stall, MisalignEr, BusErr, mem_req, mem_we;

    int checks = 0;
    int errors = 0;

    dmem_bus_ctrl #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .CLK(CLK), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
        .MisalignEr(MisalignEr), .BusErr(BusErr), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata, rdata;
        logic        ack;
        logic        e_stall, e_req, e_we;
        logic [31:0] e_addr, e_rdata;
        logic        e_mis, e_berr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, logic ack, logic e_stall, logic e_req,
                                logic e_we, logic [31:0] e_addr, logic [31:0] e_rdata,
                                logic e_mis, logic e_berr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ack = ack;
        v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr;
        v.e_rdata = e_rdata; v.e_mis = e_mis; v.e_berr = e_berr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input logic ack);
        MemRead = rd; MemWrite = wr; Addr = addr; WriteData = wd;
        mem_rdata = rdata; mem_ack = ack;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- Reset state ----
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_err", {30'd0, MisalignEr, BusErr}, 32'd0);
        next_cycle();
        reset = 1'b1;

        // ---- Vector table: load with k=3, misaligned store, back-to-back loads ----
        //              rd wr addr       wdata  rdata          ack  stall req we  maddr      rdata          mis berr
        vecs.push_back(mk(1, 0, 32'h40, 32'h0,  32'h0,         0,   1, 0, 0, 32'h0,  32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 32'h40, 32'h0,  32'h0,         0,   1, 1, 0, 32'h40, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 32'h40, 32'h0,  32'h0,         0,   1, 1, 0, 32'h40, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 32'h40, 32'h0,  32'h0,         0,   1, 1, 0, 32'h40, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 32'h40, 32'h0,  32'h1234ABCD,  1,   1, 1, 0, 32'h40, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 32'h40, 32'h0,  32'h0,         0,   0, 0, 0, 32'h40, 32'h1234ABCD,  0, 0));
        vecs.push_back(mk(0, 1, 32'h13, 32'hFF, 32'h0,         0,   0, 0, 0, 32'h40, 32'h1234ABCD,  0, 0));
        vecs.push_back(mk(0, 0, 32'h0,  32'h0,  32'h0,         0,   0, 0, 0, 32'h40, 32'h0,         1, 0));
        vecs.push_back(mk(0, 0, 32'h0,  32'h0,  32'h0,         0,   0, 0, 0, 32'h40, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 32'h0,  32'h0,  32'h0,         0,   1, 0, 0, 32'h40, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 32'h0,  32'h0,  32'h0,         0,   1, 1, 0, 32'h0,  32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 32'h0,  32'h0,  32'h11111111,  1,   1, 1, 0, 32'h0,  32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 32'h0,  32'h0,  32'h0,         0,   0, 0, 0, 32'h0,  32'h11111111,  0, 0));
        vecs.push_back(mk(1, 0, 32'h4,  32'h0,  32'h0,         0,   1, 0, 0, 32'h0,  32'h11111111,  0, 0));
        vecs.push_back(mk(1, 0, 32'h4,  32'h0,  32'h0,         0,   1, 1, 0, 32'h4,  32'h11111111,  0, 0));
        vecs.push_back(mk(1, 0, 32'h4,  32'h0,  32'h22222222,  1,   1, 1, 0, 32'h4,  32'h11111111,  0, 0));
        vecs.push_back(mk(1, 0, 32'h4,  32'h0,  32'h0,         0,   0, 0, 0, 32'h4,  32'h22222222,  0, 0));
        vecs.push_back(mk(0, 0, 32'h0,  32'h0,  32'h0,         0,   0, 0, 0, 32'h4,  32'h22222222,  0, 0));
        vecs.push_back(mk(0, 0, 32'h0,  32'h0,  32'h33333333,  1,   0, 0, 0, 32'h4,  32'h22222222,  0, 0));
        vecs.push_back(mk(0, 0, 32'h0,  32'h0,  32'h0,         0,   0, 0, 0, 32'h4,  32'h22222222,  0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].ack);
            @(negedge CLK);
            chk($sformatf("v%0d_stall", i), {31'd0, Stall}, {31'd0, vecs[i].e_stall});
            chk($sformatf("v%0d_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d_maddr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_rdata", i), ReadData, vecs[i].e_rdata);
            chk($sformatf("v%0d_mis", i), {31'd0, MisalignEr}, {31'd0, vecs[i].e_mis});
            chk($sformatf("v%0d_berr", i), {31'd0, BusErr}, {31'd0, vecs[i].e_berr});
            next_cycle();
        end

        // ---- Timeout: no ack, mem_req high 16 cycles then BusErr ----
        drive(1, 0, 32'h80, 0, 0, 0);
        @(negedge CLK);
        chk("to_stall0", {31'd0, Stall}, 32'd1);
        next_cycle();
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            chk($sformatf("to_req%0d", i), {31'd0, mem_req}, 32'd1);
            chk($sformatf("to_stall%0d", i), {31'd0, Stall}, 32'd1);
            chk($sformatf("to_berr%0d", i), {31'd0, BusErr}, 32'd0);
            next_cycle();
        end
        @(negedge CLK);
        chk("to_req_end", {31'd0, mem_req}, 32'd0);
        chk("to_berr", {31'd0, BusErr}, 32'd1);
        chk("to_rdata", ReadData, 32'hDEADBEEF);
        chk("to_stall_done", {31'd0, Stall}, 32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("to_berr_pulse", {31'd0, BusErr}, 32'd0);
        next_cycle();

        // ---- Ack in the last timeout cycle counts as ack ----
        drive(1, 0, 32'h84, 0, 0, 0);
        next_cycle();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) drive(1, 0, 32'h84, 0, 32'hCAFEF00D, 1);
            @(negedge CLK);
            chk($sformatf("ta_req%0d", i), {31'd0, mem_req}, 32'd1);
            next_cycle();
        end
        drive(1, 0, 32'h84, 0, 0, 0);
        @(negedge CLK);
        chk("ta_berr", {31'd0, BusErr}, 32'd0);
        chk("ta_rdata", ReadData, 32'hCAFEF00D);
        chk("ta_stall", {31'd0, Stall}, 32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("ta_berr_next", {31'd0, BusErr}, 32'd0);
        next_cycle();

        // ---- Reset mid-REQ ----
        drive(1, 0, 32'h90, 0, 0, 0);
        next_cycle();
        @(negedge CLK);
        chk("rr_req_before", {31'd0, mem_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rr_req_async", {31'd0, mem_req}, 32'd0);
        chk("rr_stall", {31'd0, Stall}, 32'd0);
        chk("rr_rdata", ReadData, 32'd0);
        chk("rr_maddr", mem_addr, 32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 32'h5555AAAA, 1);
        #2;
        reset = 1'b1;
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("rr_late_ack_rdata", ReadData, 32'd0);
        chk("rr_late_ack_req", {31'd0, mem_req}, 32'd0);
        next_cycle();

        // ---- Store 0x8=0xA5 followed by a load of 0xC ----
`ifdef POSTED_WRITE_EN
        drive(0, 1, 32'h8, 32'hA5, 0, 0);
        @(negedge CLK);
        chk("pw_store_stall", {31'd0, Stall}, 32'd0);
        next_cycle();
        drive(1, 0, 32'hC, 0, 0, 0);
        @(negedge CLK);
        chk("pw_ld_stall1", {31'd0, Stall}, 32'd1);
        chk("pw_req", {31'd0, mem_req}, 32'd1);
        chk("pw_we", {31'd0, mem_we}, 32'd1);
        chk("pw_addr", mem_addr, 32'h8);
        chk("pw_wdata", mem_wdata, 32'hA5);
        next_cycle();
        drive(1, 0, 32'hC, 0, 0, 1);
        @(negedge CLK);
        chk("pw_ld_stall2", {31'd0, Stall}, 32'd1);
        next_cycle();
        drive(1, 0, 32'hC, 0, 0, 0);
        @(negedge CLK);
        chk("pw_ld_stall3", {31'd0, Stall}, 32'd1);
        chk("pw_idle_req", {31'd0, mem_req}, 32'd0);
        next_cycle();
        drive(1, 0, 32'hC, 0, 32'h77, 1);
        @(negedge CLK);
        chk("pw_ld_req", {31'd0, mem_req}, 32'd1);
        chk("pw_ld_we", {31'd0, mem_we}, 32'd0);
        chk("pw_ld_addr", mem_addr, 32'hC);
        next_cycle();
        drive(1, 0, 32'hC, 0, 0, 0);
        @(negedge CLK);
        chk("pw_ld_done_stall", {31'd0, Stall}, 32'd0);
        chk("pw_ld_rdata", ReadData, 32'h77);
        next_cycle();
`else
        drive(0, 1, 32'h8, 32'hA5, 0, 0);
        @(negedge CLK);
        chk("st_stall0", {31'd0, Stall}, 32'd1);
        next_cycle();
        drive(0, 1, 32'h8, 32'hA5, 32'h99999999, 1);
        @(negedge CLK);
        chk("st_stall1", {31'd0, Stall}, 32'd1);
        chk("st_req", {31'd0, mem_req}, 32'd1);
        chk("st_we", {31'd0, mem_we}, 32'd1);
        chk("st_addr", mem_addr, 32'h8);
        chk("st_wdata", mem_wdata, 32'hA5);
        next_cycle();
        drive(0, 1, 32'h8, 32'hA5, 0, 0);
        @(negedge CLK);
        chk("st_done_stall", {31'd0, Stall}, 32'd0);
        chk("st_done_req", {31'd0, mem_req}, 32'd0);
        chk("st_rdata_kept", ReadData, 32'd0);
        next_cycle();
`endif
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
